bus_cycle_ctrl: RTL and testbench



---
 rtl/bus_ctrl_pkg.sv | 36 +++
 rtl/bus_cycle_ctrl_arb.sv | 43 ++++
 rtl/bus_cycle_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bus_ctrl_pkg
// Shared types and constants for the 8088-style bus cycle sequencer.
//   bus_state_t : bus cycle phase (IDLE, T1, T2, T3, TW, T4)
//   bus_req_t   : one requester's latched cycle description
//   STROBE_*    : levels for the active-low RD / WR / DEN pins
// -----------------------------------------------------------------------------
package bus_ctrl_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  // RD, WR and DEN are active low.
  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

  // Read data returned when a cycle is abandoned after too many wait states.
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    TW,
    T4
  } bus_state_t;

  typedef struct packed {
    logic              we;
    logic              iom;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_cycle_ctrl_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter.
//   clk  : clock
//   srst : synchronous active-high reset (tie priority returns to requester 0)
//   en   : arbitration window; grant is zero and the pointer holds when low
//   req  : request vector
//   gnt  : one-hot grant (combinational from req, en and the pointer)
// The pointer names the requester that wins a tie. It is updated on every
// grant, so the requester granted most recently loses the next tie.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       srst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_reg;  // 0: requester 0 wins a tie, 1: requester 1 wins a tie

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_reg ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      prio_reg <= 1'b0;
    end else if (|gnt) begin
      // Granting requester 0 hands the tie to requester 1, and vice versa.
      prio_reg <= gnt[0];
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// bus_cycle_ctrl
// Minimum-mode 8088-style bus cycle sequencer with a two-port round-robin
// arbiter. Each grant runs one T1-T2-T3-(TW)*-T4 byte cycle.
//
// Requester side (per requester i):
//   REQ[i], REQ_WE[i], REQ_IOM[i], REQ_ADDR[i], REQ_WDATA[i]  request + payload
//   GNT[i]  owner flag T1..T4    DONE[i]  one-cycle pulse in T4
//   ERR     T4 pulse for a timed-out cycle
//   RDATA   captured read data, held until the next capture
// Bus side:
//   READY   device ready, sampled at the end of T3 and each TW
//   ALE, RD, WR, DEN (active low), IOM, DTR, A_OUT[19:8]
//   AD_OUT / AD_OE / AD_IN  multiplexed low address / data byte
//
// Every bus pin comes from a flop or from a decode of the state register and
// the latched request; REQ and READY only reach the pins through registers.
// -----------------------------------------------------------------------------
module bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_WAIT = 15,
  parameter int WCNT_W   = 4
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NREQ-1:0]                REQ,
  input  logic [NREQ-1:0]                REQ_WE,
  input  logic [NREQ-1:0]                REQ_IOM,
  input  logic [NREQ-1:0][ADDR_W-1:0]    REQ_ADDR,
  input  logic [NREQ-1:0][DATA_W-1:0]    REQ_WDATA,
  output logic [NREQ-1:0]                GNT,
  output logic [NREQ-1:0]                DONE,
  output logic                           ERR,
  output logic [DATA_W-1:0]              RDATA,
  input  logic                           READY,
  output logic                           ALE,
  output logic                           RD,
  output logic                           WR,
  output logic                           IOM,
  output logic                           DTR,
  output logic                           DEN,
  output logic [ADDR_W-9:0]              A_OUT,
  output logic [DATA_W-1:0]              AD_OUT,
  output logic                           AD_OE,
  input  logic [DATA_W-1:0]              AD_IN
);

  bus_state_t        state_reg;
  bus_req_t          req_reg;     // owner's payload, latched entering T1
  logic [WCNT_W-1:0] wcnt_reg;    // TW states spent in the current cycle

  bus_req_t          req_in [NREQ];
  bus_req_t          win_req;
  logic [1:0]        arb_gnt;
  logic              arb_en;
  logic              wait_limit;

  // ---------------------------------------------------------------------------
  // Gather each requester's payload into the shared request struct.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_in[gi] = '{
      we:    REQ_WE[gi],
      iom:   REQ_IOM[gi],
      addr:  REQ_ADDR[gi],
      wdata: REQ_WDATA[gi]
    };
  end

  // ---------------------------------------------------------------------------
  // Arbitration happens only when the bus is free to start a new cycle:
  // in IDLE and in T4 (which may chain straight into T1).
  // ---------------------------------------------------------------------------
  assign arb_en = (state_reg == IDLE) || (state_reg == T4);

  rr_arbiter2 u_arb (
    .clk  (CLK),
    .srst (RESET),
    .en   (arb_en),
    .req  (REQ),
    .gnt  (arb_gnt)
  );

  assign win_req    = arb_gnt[1] ? req_in[1] : req_in[0];
  assign wait_limit = (wcnt_reg == WCNT_W'(MAX_WAIT));

  // ---------------------------------------------------------------------------
  // Address-side outputs decode straight from the latched request. The low
  // AD byte carries the address only during T1 and the write data afterwards;
  // AD_OE decides whether the pins actually drive it.
  // ---------------------------------------------------------------------------
  assign A_OUT  = req_reg.addr[ADDR_W-1:8];
  assign AD_OUT = (state_reg == T1) ? req_reg.addr[7:0] : req_reg.wdata;
  assign IOM    = req_reg.iom;
  assign DTR    = req_reg.we;

  // ---------------------------------------------------------------------------
  // Cycle sequencer. Strobes are registered: each transition loads the
  // values that belong to the state being entered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      req_reg   <= '0;
      wcnt_reg  <= '0;
      GNT       <= '0;
      DONE      <= '0;
      ERR       <= 1'b0;
      RDATA     <= '0;
      ALE       <= 1'b0;
      RD        <= STROBE_OFF;
      WR        <= STROBE_OFF;
      DEN       <= STROBE_OFF;
      AD_OE     <= 1'b0;
    end else begin
      // DONE and ERR are single-cycle pulses that only T4 entry raises.
      DONE <= '0;
      ERR  <= 1'b0;

      case (state_reg)
        IDLE, T4: begin
          if (|arb_gnt) begin
            // Start a cycle: latch the winner and present the address.
            state_reg <= T1;
            req_reg   <= win_req;
            GNT       <= arb_gnt;
            wcnt_reg  <= '0;
            ALE       <= 1'b1;
            AD_OE     <= 1'b1;
            RD        <= STROBE_OFF;
            WR        <= STROBE_OFF;
            DEN       <= STROBE_OFF;
          end else begin
            state_reg <= IDLE;
            GNT       <= '0;
            ALE       <= 1'b0;
            AD_OE     <= 1'b0;
            RD        <= STROBE_OFF;
            WR        <= STROBE_OFF;
            DEN       <= STROBE_OFF;
          end
        end

        T1: begin
          state_reg <= T2;
          ALE       <= 1'b0;
          DEN       <= STROBE_ON;
          if (req_reg.we) begin
            WR    <= STROBE_ON;
            AD_OE <= 1'b1;
          end else begin
            // Release the AD bus so the device can drive read data.
            RD    <= STROBE_ON;
            AD_OE <= 1'b0;
          end
        end

        T2: begin
          state_reg <= T3;
        end

        T3, TW: begin
          if (READY || wait_limit) begin
            state_reg <= T4;
            DONE      <= GNT;
            ERR       <= !READY;
            RD        <= STROBE_OFF;
            WR        <= STROBE_OFF;
            DEN       <= STROBE_OFF;
            AD_OE     <= 1'b0;
            if (!req_reg.we) begin
              RDATA <= READY ? AD_IN : TIMEOUT_RDATA;
            end
          end else begin
            state_reg <= TW;
            wcnt_reg  <= wcnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          GNT       <= '0;
          ALE       <= 1'b0;
          AD_OE     <= 1'b0;
          RD        <= STROBE_OFF;
          WR        <= STROBE_OFF;
          DEN       <= STROBE_OFF;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants.
  // ---------------------------------------------------------------------------
  a_gnt_onehot : assert property (@(posedge CLK) disable iff (RESET)
    $onehot0(GNT));

  a_ale_only_t1 : assert property (@(posedge CLK) disable iff (RESET)
    ALE |-> (state_reg == T1));

  a_rd_wr_excl : assert property (@(posedge CLK) disable iff (RESET)
    !(RD == STROBE_ON && WR == STROBE_ON));

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_cycle_ctrl
// Directed bench for bus_cycle_ctrl. Inputs change and outputs are sampled on
// the falling clock edge, half a cycle away from the active rising edge.
// strobes = {ALE, RD, WR, DEN, AD_OE, IOM, DTR}.
// -----------------------------------------------------------------------------
module tb_bus_cycle_ctrl;
  import bus_ctrl_pkg::*;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [1:0]       REQ, REQ_WE, REQ_IOM;
  logic [1:0][19:0] REQ_ADDR;
  logic [1:0][7:0]  REQ_WDATA;
  logic             READY;
  logic [7:0]       AD_IN;
  logic [1:0]       GNT, DONE;
  logic             ERR;
  logic [7:0]       RDATA;
  logic             ALE, RD, WR, IOM, DTR, DEN, AD_OE;
  logic [11:0]      A_OUT;
  logic [7:0]       AD_OUT;
  logic [6:0]       strobes;

  int n_checks = 0;
  int n_pass   = 0;

  assign strobes = {ALE, RD, WR, DEN, AD_OE, IOM, DTR};

  always #5 CLK = ~CLK;

  bus_cycle_ctrl #(.NREQ(2), .MAX_WAIT(15), .WCNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_IOM(REQ_IOM),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .GNT(GNT), .DONE(DONE),
    .ERR(ERR), .RDATA(RDATA), .READY(READY), .ALE(ALE), .RD(RD), .WR(WR),
    .IOM(IOM), .DTR(DTR), .DEN(DEN), .A_OUT(A_OUT), .AD_OUT(AD_OUT),
    .AD_OE(AD_OE), .AD_IN(AD_IN)
  );

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    n_checks++;
    if ({GNT, DONE, ERR, RDATA} !== 13'h0)
      $display("FAIL reset_ctl: got %h expected %h", {GNT, DONE, ERR, RDATA}, 13'h0);
    else n_pass++;
    n_checks++;
    if (strobes !== 7'b0111000)
      $display("FAIL reset_strobes: got %b expected %b", strobes, 7'b0111000);
    else n_pass++;
    n_checks++;
    if ({A_OUT, AD_OUT} !== 20'h0)
      $display("FAIL reset_addr: got %h expected %h", {A_OUT, AD_OUT}, 20'h0);
    else n_pass++;
    RESET = 1'b0;
    step();
    n_checks++;
    if (GNT !== 2'b00 || ALE !== 1'b0)
      $display("FAIL reset_idle: got gnt=%b ale=%b expected gnt=00 ale=0", GNT, ALE);
    else n_pass++;
    $display("txn reset complete");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mem_read();
    REQ = 2'b01; REQ_WE[0] = 1'b0; REQ_IOM[0] = 1'b0;
    REQ_ADDR[0] = 20'h8_1234; READY = 1'b1; AD_IN = 8'h5A;
    step();  // T1
    n_checks++;
    if (strobes !== 7'b1111100) $display("FAIL rd_t1_strobes: got %b expected %b", strobes, 7'b1111100);
    else n_pass++;
    n_checks++;
    if (GNT !== 2'b01) $display("FAIL rd_t1_gnt: got %b expected %b", GNT, 2'b01);
    else n_pass++;
    n_checks++;
    if ({A_OUT, AD_OUT} !== 20'h8_1234) $display("FAIL rd_t1_addr: got %h expected %h", {A_OUT, AD_OUT}, 20'h8_1234);
    else n_pass++;
    step();  // T2
    n_checks++;
    if (strobes !== 7'b0010000) $display("FAIL rd_t2_strobes: got %b expected %b", strobes, 7'b0010000);
    else n_pass++;
    step();  // T3
    n_checks++;
    if (strobes !== 7'b0010000 || DONE !== 2'b00)
      $display("FAIL rd_t3: got strobes=%b done=%b expected 0010000 00", strobes, DONE);
    else n_pass++;
    step();  // T4
    n_checks++;
    if (DONE !== 2'b01 || ERR !== 1'b0) $display("FAIL rd_t4_done: got done=%b err=%b expected 01 0", DONE, ERR);
    else n_pass++;
    n_checks++;
    if (RDATA !== 8'h5A) $display("FAIL rd_rdata: got %h expected %h", RDATA, 8'h5A);
    else n_pass++;
    n_checks++;
    if (strobes !== 7'b0111000 || GNT !== 2'b01)
      $display("FAIL rd_t4_bus: got strobes=%b gnt=%b expected 0111000 01", strobes, GNT);
    else n_pass++;
    $display("txn mem_read req0 addr=81234 rdata=%h", RDATA);
    REQ = 2'b00;
    step();  // IDLE
    n_checks++;
    if (GNT !== 2'b00 || DONE !== 2'b00) $display("FAIL rd_after: got gnt=%b done=%b expected 00 00", GNT, DONE);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_io_write();
    REQ = 2'b10; REQ_WE[1] = 1'b1; REQ_IOM[1] = 1'b1;
    REQ_ADDR[1] = 20'h0_0F00; REQ_WDATA[1] = 8'hC3; READY = 1'b0;
    step();  // T1
    n_checks++;
    if (strobes !== 7'b1111111 || GNT !== 2'b10)
      $display("FAIL wr_t1: got strobes=%b gnt=%b expected 1111111 10", strobes, GNT);
    else n_pass++;
    n_checks++;
    if ({A_OUT, AD_OUT} !== 20'h0_0F00) $display("FAIL wr_t1_addr: got %h expected %h", {A_OUT, AD_OUT}, 20'h0_0F00);
    else n_pass++;
    // T2, T3, TW, TW: WR low with write data driven; READY rises for the 3rd sample.
    for (int cyc = 2; cyc <= 5; cyc++) begin
      step();
      n_checks++;
      if (strobes !== 7'b0100111 || AD_OUT !== 8'hC3 || DONE !== 2'b00)
        $display("FAIL wr_data_c%0d: got strobes=%b ad=%h done=%b expected 0100111 c3 00", cyc, strobes, AD_OUT, DONE);
      else n_pass++;
      if (cyc == 5) READY = 1'b1;
    end
    step();  // T4 at clock 6
    n_checks++;
    if (DONE !== 2'b10 || ERR !== 1'b0) $display("FAIL wr_done: got done=%b err=%b expected 10 0", DONE, ERR);
    else n_pass++;
    n_checks++;
    if (strobes !== 7'b0111011) $display("FAIL wr_t4_strobes: got %b expected %b", strobes, 7'b0111011);
    else n_pass++;
    n_checks++;
    if (RDATA !== 8'h5A) $display("FAIL wr_rdata_held: got %h expected %h", RDATA, 8'h5A);
    else n_pass++;
    $display("txn io_write req1 addr=00f00 wdata=c3");
    REQ = 2'b00;
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int idle_seen = 0;
    REQ = 2'b11; REQ_WE = 2'b00; REQ_IOM = 2'b00;
    REQ_ADDR[0] = 20'h1_0000; REQ_ADDR[1] = 20'h2_0000; READY = 1'b1; AD_IN = 8'h3C;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      automatic logic [1:0] exp_g = ((((cyc - 1) / 4) % 2) == 0) ? 2'b01 : 2'b10;
      step();
      if (dut.state_reg == IDLE) idle_seen++;
      if ((cyc % 4) == 1) begin
        n_checks++;
        if (ALE !== 1'b1 || GNT !== exp_g)
          $display("FAIL b2b_t1_c%0d: got ale=%b gnt=%b expected 1 %b", cyc, ALE, GNT, exp_g);
        else n_pass++;
      end
      if ((cyc % 4) == 0) begin
        n_checks++;
        if (DONE !== exp_g) $display("FAIL b2b_done_c%0d: got %b expected %b", cyc, DONE, exp_g);
        else n_pass++;
        $display("txn b2b grant=%b done at clock %0d", exp_g, cyc);
      end
    end
    REQ = 2'b00;
    n_checks++;
    if (idle_seen != 0) $display("FAIL b2b_no_idle: got %0d idle clocks expected 0", idle_seen);
    else n_pass++;
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    int done_at = 0;
    int rd_low  = 0;
    logic err_v = 1'b0;
    REQ = 2'b01; REQ_WE[0] = 1'b0; REQ_IOM[0] = 1'b0;
    REQ_ADDR[0] = 20'h2_0040; READY = 1'b0; AD_IN = 8'h00;
    for (int cyc = 1; cyc <= 40 && done_at == 0; cyc++) begin
      step();
      if (RD === 1'b0) rd_low++;
      if (DONE !== 2'b00) begin done_at = cyc; err_v = ERR; end
    end
    REQ = 2'b00;
    n_checks++;
    if (done_at != 19) $display("FAIL to_done_clock: got %0d expected %0d", done_at, 19);
    else n_pass++;
    n_checks++;
    if (rd_low != 17) $display("FAIL to_rd_low: got %0d expected %0d", rd_low, 17);
    else n_pass++;
    n_checks++;
    if (err_v !== 1'b1) $display("FAIL to_err: got %b expected 1", err_v);
    else n_pass++;
    n_checks++;
    if (RDATA !== 8'hFF) $display("FAIL to_rdata: got %h expected %h", RDATA, 8'hFF);
    else n_pass++;
    $display("txn timeout read req0 done at clock %0d err=%b", done_at, err_v);
    step();
    n_checks++;
    if (ERR !== 1'b0 || DONE !== 2'b00) $display("FAIL to_pulse: got err=%b done=%b expected 0 00", ERR, DONE);
    else n_pass++;
    // Normal read afterwards.
    done_at = 0; err_v = 1'b1;
    REQ = 2'b01; READY = 1'b1; AD_IN = 8'h77;
    for (int cyc = 1; cyc <= 10 && done_at == 0; cyc++) begin
      step();
      if (DONE !== 2'b00) begin done_at = cyc; err_v = ERR; end
    end
    REQ = 2'b00;
    n_checks++;
    if (done_at != 4 || err_v !== 1'b0 || RDATA !== 8'h77)
      $display("FAIL to_recover: got clock=%0d err=%b rdata=%h expected 4 0 77", done_at, err_v, RDATA);
    else n_pass++;
    $display("txn recovery read req0 rdata=%h", RDATA);
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int dones = 0;
    REQ = 2'b01; REQ_WE[0] = 1'b1; REQ_IOM[0] = 1'b0;
    REQ_ADDR[0] = 20'h3_4567; REQ_WDATA[0] = 8'h11; READY = 1'b1;
    step();  // T1
    step();  // T2
    n_checks++;
    if (WR !== 1'b0 || DEN !== 1'b0) $display("FAIL rst_pre_t2: got wr=%b den=%b expected 0 0", WR, DEN);
    else n_pass++;
    RESET = 1'b1;
    step();
    n_checks++;
    if ({WR, DEN, AD_OE} !== 3'b110 || GNT !== 2'b00 || DONE !== 2'b00)
      $display("FAIL rst_mid_bus: got wr/den/oe=%b gnt=%b done=%b expected 110 00 00", {WR, DEN, AD_OE}, GNT, DONE);
    else n_pass++;
    n_checks++;
    if (dut.state_reg !== IDLE) $display("FAIL rst_mid_state: got %0d expected %0d", dut.state_reg, IDLE);
    else n_pass++;
    n_checks++;
    if (A_OUT !== 12'h0) $display("FAIL rst_mid_addr: got %h expected %h", A_OUT, 12'h0);
    else n_pass++;
    RESET = 1'b0; REQ = 2'b00;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step();
      if (DONE !== 2'b00) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL rst_no_done: got %0d pulses expected 0", dones);
    else n_pass++;
    $display("txn write aborted by reset");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_consecutive_reads();
    REQ = 2'b01; REQ_WE[0] = 1'b0; REQ_IOM[0] = 1'b0;
    REQ_ADDR[0] = 20'h0_0100; READY = 1'b1; AD_IN = 8'hA0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      automatic logic [1:0] exp_d = ((cyc % 4) == 0) ? 2'b01 : 2'b00;
      step();
      n_checks++;
      if (GNT !== 2'b01 || DONE !== exp_d)
        $display("FAIL seq_c%0d: got gnt=%b done=%b expected 01 %b", cyc, GNT, DONE, exp_d);
      else n_pass++;
      if ((cyc % 4) == 0) begin
        n_checks++;
        if (RDATA !== 8'(8'hA0 + cyc - 1))
          $display("FAIL seq_rdata_c%0d: got %h expected %h", cyc, RDATA, 8'(8'hA0 + cyc - 1));
        else n_pass++;
        $display("txn seq read req0 done at clock %0d rdata=%h", cyc, RDATA);
      end
      AD_IN = 8'(8'hA0 + cyc);
      if (cyc == 12) REQ = 2'b00;
    end
    step();
    n_checks++;
    if (GNT !== 2'b00) $display("FAIL seq_release: got %b expected %b", GNT, 2'b00);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    RESET = 1'b1; REQ = '0; REQ_WE = '0; REQ_IOM = '0;
    REQ_ADDR = '0; REQ_WDATA = '0; READY = 1'b0; AD_IN = '0;
    @(negedge CLK);
    test_reset();
    test_mem_read();
    test_io_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_consecutive_reads();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
